// File: rtl/exu_wbu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : exu_wbu_pkg                                              |
// | Description : Shared encodings for the execute-stage writeback unit:   |
// |               writeback kinds, load sizes, FSM states, defaults.       |
// | Revision    : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
package exu_wbu_pkg;

  // Default datapath width of the core configuration.
  localparam int unsigned ISA_WIDTH_DEFAULT = 32;

  // Writeback kind encodings carried with each completed instruction.
  localparam logic [1:0] WB_KIND_NONE = 2'd0;
  localparam logic [1:0] WB_KIND_ALU  = 2'd1;
  localparam logic [1:0] WB_KIND_LOAD = 2'd2;
  localparam logic [1:0] WB_KIND_RSVD = 2'd3;

  // Load access size encodings.
  localparam logic [1:0] LD_SIZE_B = 2'd0;
  localparam logic [1:0] LD_SIZE_H = 2'd1;
  localparam logic [1:0] LD_SIZE_W = 2'd2;
  localparam logic [1:0] LD_SIZE_D = 2'd3;

  // Writeback FSM: either free to accept, or parked on an outstanding load.
  typedef enum logic [0:0] {
    WBU_IDLE     = 1'b0,
    WBU_WAIT_MEM = 1'b1
  } wbu_state_e;

endpackage : exu_wbu_pkg
`default_nettype wire

// File: rtl/exu_wbu_ld_ext.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : exu_wbu_ld_ext                                           |
// | Description : Load data aligner. Shifts the memory word down to the    |
// |               addressed byte, keeps B/H/W/D bits and sign- or          |
// |               zero-extends to the datapath width.                      |
// | Revision    : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module exu_wbu_ld_ext
  import exu_wbu_pkg::*;
#(
  parameter int ISA_WIDTH = ISA_WIDTH_DEFAULT,
  localparam int OFF_W    = $clog2(ISA_WIDTH / 8)
) (
  input  logic [ISA_WIDTH-1:0] data_i,
  input  logic [OFF_W-1:0]     offset_i,
  input  logic [1:0]           size_i,
  input  logic                 unsigned_i,
  output logic [ISA_WIDTH-1:0] ext_o
);

  logic [ISA_WIDTH-1:0] w_shifted;
  logic [ISA_WIDTH-1:0] w_byte;
  logic [ISA_WIDTH-1:0] w_half;
  logic [ISA_WIDTH-1:0] w_word;
  logic [ISA_WIDTH-1:0] w_dword;

  // Logical right shift: bytes past the top of the word come in as zero,
  // which is exactly the behaviour wanted for misaligned accesses.
  assign w_shifted = data_i >> {offset_i, 3'b000};

  assign w_byte = {{(ISA_WIDTH-8){~unsigned_i & w_shifted[7]}},  w_shifted[7:0]};
  assign w_half = {{(ISA_WIDTH-16){~unsigned_i & w_shifted[15]}}, w_shifted[15:0]};

  // Word and doubleword only differ from the full width on a 64-bit datapath;
  // on 32 bits a D access degenerates to W and W needs no extension.
  generate
    if (ISA_WIDTH == 64) begin : g_isa64
      assign w_word  = {{32{~unsigned_i & w_shifted[31]}}, w_shifted[31:0]};
      assign w_dword = w_shifted;
    end else begin : g_isa32
      assign w_word  = w_shifted;
      assign w_dword = w_shifted;
    end
  endgenerate

  // Pick the extended value matching the access size.
  always_comb begin
    ext_o = w_word;
    case (size_i)
      LD_SIZE_B: ext_o = w_byte;
      LD_SIZE_H: ext_o = w_half;
      LD_SIZE_W: ext_o = w_word;
      LD_SIZE_D: ext_o = w_dword;
      default:   ext_o = w_word;
    endcase
  end

endmodule : exu_wbu_ld_ext
`default_nettype wire

// File: rtl/exu_wbu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : exu_wbu                                                  |
// | Description : Execute-stage writeback unit. Accepts one completed      |
// |               instruction per handshake, waits for load data when      |
// |               needed and drives a registered GPR write port plus a     |
// |               per-instruction retire pulse.                            |
// | Revision    : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module exu_wbu
  import exu_wbu_pkg::*;
#(
  parameter int ISA_WIDTH      = ISA_WIDTH_DEFAULT,
  parameter int REG_ADDR_WIDTH = 5,
  localparam int OFF_W         = $clog2(ISA_WIDTH / 8)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_kind,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic [ISA_WIDTH-1:0]      in_alu_result,
  input  logic [1:0]                in_ld_size,
  input  logic                      in_ld_unsigned,
  input  logic [OFF_W-1:0]          in_addr_lo,
  input  logic                      mem_r_valid,
  input  logic [ISA_WIDTH-1:0]      mem_r_data,
  output logic                      gpr_w_en,
  output logic [REG_ADDR_WIDTH-1:0] gpr_w_addr,
  output logic [ISA_WIDTH-1:0]      gpr_w_data,
  output logic                      wb_done
);

  wbu_state_e                state_q, state_d;

  // Fields of the outstanding load, held while waiting for memory.
  logic [REG_ADDR_WIDTH-1:0] ld_rd_q, ld_rd_d;
  logic [1:0]                ld_size_q, ld_size_d;
  logic                      ld_uns_q, ld_uns_d;
  logic [OFF_W-1:0]          ld_off_q, ld_off_d;

  // Registered write port and retire pulse.
  logic                      gpr_w_en_q, gpr_w_en_d;
  logic [REG_ADDR_WIDTH-1:0] gpr_w_addr_q, gpr_w_addr_d;
  logic [ISA_WIDTH-1:0]      gpr_w_data_q, gpr_w_data_d;
  logic                      wb_done_q, wb_done_d;

  logic [ISA_WIDTH-1:0]      w_ld_value;

  exu_wbu_ld_ext #(
    .ISA_WIDTH (ISA_WIDTH)
  ) u_ld_ext (
    .data_i     (mem_r_data),
    .offset_i   (ld_off_q),
    .size_i     (ld_size_q),
    .unsigned_i (ld_uns_q),
    .ext_o      (w_ld_value)
  );

  // Ready is a pure decode of state so upstream sees it without a cycle lag.
  assign in_ready   = (state_q == WBU_IDLE);

  assign gpr_w_en   = gpr_w_en_q;
  assign gpr_w_addr = gpr_w_addr_q;
  assign gpr_w_data = gpr_w_data_q;
  assign wb_done    = wb_done_q;

  // Next-state and output decode; address/data only move when a write happens.
  always_comb begin
    state_d      = state_q;
    ld_rd_d      = ld_rd_q;
    ld_size_d    = ld_size_q;
    ld_uns_d     = ld_uns_q;
    ld_off_d     = ld_off_q;
    gpr_w_en_d   = 1'b0;
    gpr_w_addr_d = gpr_w_addr_q;
    gpr_w_data_d = gpr_w_data_q;
    wb_done_d    = 1'b0;

    case (state_q)
      WBU_IDLE: begin
        if (in_valid) begin
          case (in_kind)
            WB_KIND_ALU: begin
              wb_done_d = 1'b1;
              if (in_rd != '0) begin
                gpr_w_en_d   = 1'b1;
                gpr_w_addr_d = in_rd;
                gpr_w_data_d = in_alu_result;
              end
            end
            WB_KIND_LOAD: begin
              ld_rd_d   = in_rd;
              ld_size_d = in_ld_size;
              ld_uns_d  = in_ld_unsigned;
              ld_off_d  = in_addr_lo;
              state_d   = WBU_WAIT_MEM;
            end
            default: begin
              // NONE and the reserved kind retire without touching the GPRs.
              wb_done_d = 1'b1;
            end
          endcase
        end
      end

      WBU_WAIT_MEM: begin
        if (mem_r_valid) begin
          wb_done_d = 1'b1;
          state_d   = WBU_IDLE;
          if (ld_rd_q != '0) begin
            gpr_w_en_d   = 1'b1;
            gpr_w_addr_d = ld_rd_q;
            gpr_w_data_d = w_ld_value;
          end
        end
      end

      default: begin
        state_d = WBU_IDLE;
      end
    endcase
  end

  // State, captured load fields and output registers; reset abandons any load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WBU_IDLE;
      ld_rd_q      <= '0;
      ld_size_q    <= '0;
      ld_uns_q     <= 1'b0;
      ld_off_q     <= '0;
      gpr_w_en_q   <= 1'b0;
      gpr_w_addr_q <= '0;
      gpr_w_data_q <= '0;
      wb_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_rd_q      <= ld_rd_d;
      ld_size_q    <= ld_size_d;
      ld_uns_q     <= ld_uns_d;
      ld_off_q     <= ld_off_d;
      gpr_w_en_q   <= gpr_w_en_d;
      gpr_w_addr_q <= gpr_w_addr_d;
      gpr_w_data_q <= gpr_w_data_d;
      wb_done_q    <= wb_done_d;
    end
  end

endmodule : exu_wbu
`default_nettype wire

// File: tb/tb_exu_wbu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_exu_wbu                                               |
// | Description : Bench for exu_wbu. Drives a 32-bit and a 64-bit instance |
// |               with the same directed stream and checks both against a  |
// |               byte-level transaction model every cycle.                |
// | Revision    : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module tb_exu_wbu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  in_kind = 2'd0;
  logic [4:0]  in_rd = 5'd0;
  logic [63:0] in_alu = 64'd0;
  logic [1:0]  in_size = 2'd0;
  logic        in_uns = 1'b0;
  logic [2:0]  in_off = 3'd0;
  logic        mem_v = 1'b0;
  logic [63:0] mem_d = 64'd0;

  logic        rdy32, en32, done32;
  logic [4:0]  addr32;
  logic [31:0] data32;
  logic        rdy64, en64, done64;
  logic [4:0]  addr64;
  logic [63:0] data64;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  exu_wbu #(.ISA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
    .in_kind(in_kind), .in_rd(in_rd), .in_alu_result(in_alu[31:0]),
    .in_ld_size(in_size), .in_ld_unsigned(in_uns), .in_addr_lo(in_off[1:0]),
    .mem_r_valid(mem_v), .mem_r_data(mem_d[31:0]),
    .gpr_w_en(en32), .gpr_w_addr(addr32), .gpr_w_data(data32), .wb_done(done32)
  );

  exu_wbu #(.ISA_WIDTH(64), .REG_ADDR_WIDTH(5)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64),
    .in_kind(in_kind), .in_rd(in_rd), .in_alu_result(in_alu),
    .in_ld_size(in_size), .in_ld_unsigned(in_uns), .in_addr_lo(in_off),
    .mem_r_valid(mem_v), .mem_r_data(mem_d),
    .gpr_w_en(en64), .gpr_w_addr(addr64), .gpr_w_data(data64), .wb_done(done64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-level load result: gather the addressed bytes (absent bytes are 0),
  // then fill the upper bytes with the sign or with zeros.
  function automatic logic [63:0] ld_model(input logic [63:0] d, input int off,
                                           input int sz, input bit uns, input int w);
    logic [63:0] r;
    int          nbytes;
    int          src;
    bit          s;
    nbytes = (sz == 3 && w == 32) ? 4 : (1 << sz);
    r = 64'd0;
    for (int i = 0; i < nbytes; i++) begin
      src = off + i;
      if (src < w / 8) r[i*8 +: 8] = d[src*8 +: 8];
    end
    s = !uns && r[nbytes*8-1];
    for (int i = nbytes; i < 8; i++) r[i*8 +: 8] = s ? 8'hFF : 8'h00;
    if (w == 32) r[63:32] = 32'd0;
    return r;
  endfunction

  // Transaction model: one instruction in flight at most; loads block until
  // memory answers, everything else retires the following cycle.
  logic        m_busy = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic [1:0]  m_size = 2'd0;
  logic        m_uns = 1'b0;
  logic [2:0]  m_off = 3'd0;
  logic        m_en = 1'b0;
  logic        m_done = 1'b0;
  logic [4:0]  m_addr = 5'd0;
  logic [63:0] m_d32 = 64'd0;
  logic [63:0] m_d64 = 64'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_en <= 1'b0; m_done <= 1'b0;
      m_addr <= 5'd0; m_d32 <= 64'd0; m_d64 <= 64'd0;
    end else begin
      m_en   <= 1'b0;
      m_done <= 1'b0;
      if (!m_busy && in_valid) begin
        if (in_kind == 2'd2) begin
          m_busy <= 1'b1;
          m_rd   <= in_rd; m_size <= in_size; m_uns <= in_uns; m_off <= in_off;
        end else begin
          m_done <= 1'b1;
          if (in_kind == 2'd1 && in_rd != 5'd0) begin
            m_en <= 1'b1; m_addr <= in_rd;
            m_d32 <= {32'd0, in_alu[31:0]}; m_d64 <= in_alu;
          end
        end
      end else if (m_busy && mem_v) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        if (m_rd != 5'd0) begin
          m_en   <= 1'b1; m_addr <= m_rd;
          m_d32  <= ld_model({32'd0, mem_d[31:0]}, int'(m_off[1:0]), int'(m_size), m_uns, 32);
          m_d64  <= ld_model(mem_d, int'(m_off), int'(m_size), m_uns, 64);
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("ready32", {63'd0, rdy32}, {63'd0, !m_busy});
    chk("en32",    {63'd0, en32},  {63'd0, m_en});
    chk("done32",  {63'd0, done32}, {63'd0, m_done});
    chk("addr32",  {59'd0, addr32}, {59'd0, m_addr});
    chk("data32",  {32'd0, data32}, m_d32);
    chk("ready64", {63'd0, rdy64}, {63'd0, !m_busy});
    chk("en64",    {63'd0, en64},  {63'd0, m_en});
    chk("done64",  {63'd0, done64}, {63'd0, m_done});
    chk("addr64",  {59'd0, addr64}, {59'd0, m_addr});
    chk("data64",  data64, m_d64);
  end

  // Offer an instruction (called at a negedge) and hold it until accepted.
  task automatic issue(input logic [1:0] kind, input logic [4:0] rd, input logic [63:0] alu,
                       input logic [1:0] sz, input logic uns, input logic [2:0] off);
    bit acc;
    int n;
    in_valid = 1'b1; in_kind = kind; in_rd = rd; in_alu = alu;
    in_size = sz; in_uns = uns; in_off = off;
    n = 0;
    do begin
      acc = rdy32;
      @(negedge clk);
      n++;
    end while (!acc && n < 50);
    vectors++;
    if (!acc) begin
      fails++;
      $display("FAIL accept_timeout: actual=not-accepted required=accepted at %0t", $time);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_kind  = 2'd0;
  endtask

  // Present a memory response so that it is sampled 'lat' edges from now.
  task automatic mem_resp(input int lat, input logic [63:0] d);
    repeat (lat - 1) @(negedge clk);
    mem_v = 1'b1; mem_d = d;
    @(negedge clk);
    mem_v = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("lit_reset_ready", {63'd0, rdy32}, 64'd1);
    chk("lit_reset_data",  data64, 64'd0);
    chk("lit_reset_en",    {63'd0, en64}, 64'd0);

    // ALU stream, including an x0 destination.
    issue(2'd1, 5'd5, 64'h11, 2'd0, 1'b0, 3'd0);
    chk("lit_alu1_addr", {59'd0, addr32}, 64'd5);
    chk("lit_alu1_data", {32'd0, data32}, 64'h11);
    issue(2'd1, 5'd6, 64'h22, 2'd0, 1'b0, 3'd0);
    chk("lit_alu2_data", {32'd0, data32}, 64'h22);
    issue(2'd1, 5'd0, 64'h33, 2'd0, 1'b0, 3'd0);
    chk("lit_x0_en",   {63'd0, en32}, 64'd0);
    chk("lit_x0_done", {63'd0, done32}, 64'd1);
    chk("lit_x0_hold", {32'd0, data32}, 64'h22);
    // NONE and reserved kinds retire without a write.
    issue(2'd0, 5'd3, 64'hDEAD, 2'd0, 1'b0, 3'd0);
    issue(2'd3, 5'd4, 64'hBEEF, 2'd0, 1'b0, 3'd0);
    idle();
    // Stray response while idle must be ignored.
    mem_resp(1, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);

    // LB signed, offset 2, response 3 edges after accept.
    issue(2'd2, 5'd7, 64'd0, 2'd0, 1'b0, 3'd2);
    idle();
    chk("lit_lb_waiting_ready", {63'd0, rdy32}, 64'd0);
    mem_resp(3, 64'h1280_3456);
    chk("lit_lb_data32", {32'd0, data32}, 64'hFFFF_FF80);
    chk("lit_lb_addr32", {59'd0, addr32}, 64'd7);

    // 64-bit sizes on a single memory word.
    issue(2'd2, 5'd8, 64'd0, 2'd1, 1'b1, 3'd6);
    idle();
    mem_resp(2, 64'h8765_4321_F0E1_D2C3);
    chk("lit_lhu_data64", data64, 64'h8765);
    chk("lit_lhu_data32", {32'd0, data32}, 64'hF0E1);
    issue(2'd2, 5'd9, 64'd0, 2'd2, 1'b0, 3'd4);
    idle();
    mem_resp(1, 64'h8765_4321_F0E1_D2C3);
    chk("lit_lw_data64", data64, 64'hFFFF_FFFF_8765_4321);
    issue(2'd2, 5'd10, 64'd0, 2'd3, 1'b0, 3'd0);
    idle();
    mem_resp(1, 64'h8765_4321_F0E1_D2C3);
    chk("lit_ld_data64", data64, 64'h8765_4321_F0E1_D2C3);
    chk("lit_ld_data32", {32'd0, data32}, 64'hF0E1_D2C3);

    // Load followed by an ALU op offered during the wait.
    issue(2'd2, 5'd11, 64'd0, 2'd2, 1'b1, 3'd0);
    fork
      issue(2'd1, 5'd12, 64'h99, 2'd0, 1'b0, 3'd0);
      mem_resp(2, 64'h0000_0000_CAFE_F00D);
    join
    idle();
    chk("lit_order_addr", {59'd0, addr32}, 64'd12);
    chk("lit_order_data", {32'd0, data32}, 64'h99);
    @(negedge clk);

    // Reset during WAIT_MEM with a same-cycle response.
    issue(2'd2, 5'd13, 64'd0, 2'd2, 1'b0, 3'd0);
    idle();
    rst = 1'b1; mem_v = 1'b1; mem_d = 64'h1234_5678;
    @(negedge clk);
    rst = 1'b0; mem_v = 1'b0;
    chk("lit_rstwait_en",    {63'd0, en32}, 64'd0);
    chk("lit_rstwait_data",  {32'd0, data32}, 64'd0);
    chk("lit_rstwait_ready", {63'd0, rdy32}, 64'd1);
    repeat (2) @(negedge clk);

    // Misaligned unsigned LW.
    issue(2'd2, 5'd14, 64'd0, 2'd2, 1'b1, 3'd3);
    idle();
    mem_resp(1, 64'h0000_0000_AABB_CCDD);
    chk("lit_mis_data32", {32'd0, data32}, 64'hAA);
    chk("lit_mis_data64", data64, 64'hAA);

    // Load to x0 retires without a write.
    issue(2'd2, 5'd0, 64'd0, 2'd0, 1'b0, 3'd0);
    idle();
    mem_resp(2, 64'h55);
    chk("lit_ldx0_en", {63'd0, en64}, 64'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule : tb_exu_wbu
`default_nettype wire
